uart_packet_tx: RTL and testbench



---
 rtl/uart_packet_tx.sv | 149 ++++++++++++++
 tb/tb_uart_packet_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx.sv
// Framed 8N1 UART transmitter.
// Each frame is SYNC_BYTE, then PAYLOAD_BYTES payload bytes (byte 0 first), then
// the XOR of the payload bytes. Bit timing comes from an internal cycle counter.
// tx is registered and is computed from the next FSM state, so the line follows
// the state with no extra lag.
// A frame occupies (PAYLOAD_BYTES+2)*10*CLKS_PER_BIT cycles, counted from the
// first start-bit cycle.
// frame_done marks the single IDLE cycle that follows the frame. A request taken
// in that cycle starts the next start bit on the following cycle.
module uart_packet_tx #(
   parameter int          CLKS_PER_BIT  = 564,
   parameter int          PAYLOAD_BYTES = 4,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [8*PAYLOAD_BYTES-1:0] payload_in,
   input  logic                       payload_valid,
   output logic                       payload_ready,
   output logic                       tx,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam int             BW        = $clog2(PAYLOAD_BYTES + 2);
   localparam int             PW        = 8 * PAYLOAD_BYTES;
   localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]  LAST_BYTE = BW'(PAYLOAD_BYTES + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  clk_cnt, cnt_nxt;
   logic [2:0]     bit_idx, bit_nxt;
   logic [BW-1:0]  byte_idx, byte_nxt;
   logic [PW-1:0]  payload_q;
   logic [7:0]     checksum, in_xor, cur_byte;
   logic           tx_nxt, done_nxt, accept, wrap;

   assign payload_ready = (state == IDLE);
   assign busy          = ~payload_ready;
   assign accept        = payload_valid && payload_ready;
   assign wrap          = (clk_cnt == CNT_MAX);

   // XOR of the bytes being captured on an accepting edge; it is stored beside
   // the captured word, so the checksum can never follow later payload_in changes
   always_comb begin
      in_xor = '0;
      for (int k = 0; k < PAYLOAD_BYTES; k++)
         in_xor = in_xor ^ payload_in[8*k +: 8];
   end

   // Next-state logic for the bit/byte sequencer and the frame_done pulse
   always_comb begin
      state_nxt = state;
      cnt_nxt   = clk_cnt;
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = START;
               cnt_nxt   = '0;
               bit_nxt   = '0;
               byte_nxt  = '0;
            end
         end
         START: begin
            if (wrap) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = DATA;
            end else begin
               cnt_nxt = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (wrap) begin
               cnt_nxt = '0;
               if (bit_idx == 3'd7) state_nxt = STOP;
               else                 bit_nxt   = bit_idx + 3'd1;
            end else begin
               cnt_nxt = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (wrap) begin
               cnt_nxt = '0;
               if (byte_idx < LAST_BYTE) begin
                  byte_nxt  = byte_idx + 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = clk_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte selection for the upcoming cycle: sync, payload bytes, then checksum
   always_comb begin
      cur_byte = checksum;
      if (byte_nxt == '0) cur_byte = SYNC_BYTE;
      for (int k = 0; k < PAYLOAD_BYTES; k++)
         if (byte_nxt == BW'(k + 1)) cur_byte = payload_q[8*k +: 8];
   end

   // Line level for the upcoming cycle, taken from the next state
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = cur_byte[bit_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   // State, counter, capture and output registers; reset aborts any frame at once
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         payload_q  <= '0;
         checksum   <= '0;
         tx         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         clk_cnt    <= cnt_nxt;
         bit_idx    <= bit_nxt;
         byte_idx   <= byte_nxt;
         tx         <= tx_nxt;
         frame_done <= done_nxt;
         if (accept) begin
            payload_q <= payload_in;
            checksum  <= in_xor;
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Scoreboard bench for uart_packet_tx. Accepted payloads become expected bytes
// in a queue. A serial receiver decodes tx, checks every bit cell, and pops and
// compares each byte it receives.
module tb_uart_packet_tx;

   localparam int         C    = 4;
   localparam int         PB   = 4;
   localparam int         NB   = PB + 2;
   localparam logic [7:0] SYNC = 8'hA5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [8*PB-1:0] payload_in = '0;
   logic            payload_valid = 1'b0;
   logic            payload_ready, tx, busy, frame_done;

   uart_packet_tx #(.CLKS_PER_BIT(C), .PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC)) dut (
      .clk(clk), .rst(rst), .payload_in(payload_in), .payload_valid(payload_valid),
      .payload_ready(payload_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference frame: sync, payload bytes little-end first, XOR of payload bytes
   function automatic void push_frame(input logic [8*PB-1:0] p);
      logic [7:0] x, b;
      x = 8'h00;
      exp_q.push_back(SYNC);
      for (int k = 0; k < PB; k++) begin
         b = 8'((p >> (8 * k)) & 32'hFF);
         x = x ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(x);
   endfunction

   // Receiver / monitor state
   int         mstate = 4, cnt = 0, bitn = 0, pos = 0;
   int         fstart = 0, last_start = 0, last_done = 0, n_done = 0, acc_cnt = 0;
   logic       bitval = 1'b1;
   logic [7:0] rbyte = 8'h00;
   logic [7:0] e;

   // Decode tx on the falling edge, check framing and timing, record acceptances
   always @(negedge clk) begin
      if (rst) begin
         mstate = 4;
         pos = 0;
         exp_q.delete();
      end else begin
         case (mstate)
            4: begin
               chk("post_reset_tx", 32'(tx), 1);
               chk("post_reset_ready", 32'(payload_ready), 1);
               chk("post_reset_done", 32'(frame_done), 0);
               mstate = 0;
            end
            0: begin
               chk("idle_frame_done", 32'(frame_done), 0);
               if (tx == 1'b0) begin
                  fstart = cyc; last_start = cyc;
                  chk("start_busy", 32'(busy), 1);
                  mstate = 1; bitval = 1'b0; cnt = 1; bitn = 0; rbyte = 8'h00;
               end else begin
                  chk("idle_ready", 32'(payload_ready), 1);
                  chk("idle_busy", 32'(busy), 0);
               end
            end
            2: begin
               chk("inter_byte_gap", 32'(tx), 0);
               chk("frame_busy", 32'(busy), 1);
               mstate = 1; bitval = 1'b0; cnt = 1; bitn = 0; rbyte = 8'h00;
            end
            1: begin
               chk("frame_busy", 32'(busy), 1);
               chk("frame_done_early", 32'(frame_done), 0);
               if (cnt == 0) bitval = tx;
               else chk("bit_stable", 32'(tx), 32'(bitval));
               cnt++;
               if (cnt == C) begin
                  cnt = 0;
                  if (bitn >= 1 && bitn <= 8) rbyte[bitn-1] = bitval;
                  else if (bitn == 9) begin
                     chk("stop_bit", 32'(bitval), 1);
                     if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", rbyte, cyc);
                     end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", pos), 32'(rbyte), 32'(e));
                     end
                     pos++;
                     mstate = (pos < NB) ? 2 : 3;
                  end
                  bitn++;
               end
            end
            3: begin
               chk("frame_done", 32'(frame_done), 1);
               chk("frame_len", 32'(cyc - fstart), NB * 10 * C);
               chk("done_ready", 32'(payload_ready), 1);
               n_done++; last_done = cyc; pos = 0; mstate = 0;
            end
            default: mstate = 0;
         endcase
         if (payload_valid && payload_ready) begin
            push_frame(payload_in);
            acc_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_acc(input int a);
      int t;
      t = 0;
      while (acc_cnt == a && t < 2000) begin tick(); t++; end
      if (acc_cnt == a) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: got no acceptance expected one (cycle %0d)", cyc);
      end
   endtask

   task automatic send(input logic [8*PB-1:0] p);
      int a;
      a = acc_cnt;
      payload_in = p; payload_valid = 1'b1;
      wait_acc(a);
      payload_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (n_done < target && t < 2000) begin tick(); t++; end
      chk("frame_count", 32'(n_done), 32'(target));
   endtask

   int nexp = 0, a, d, t;
   logic [31:0] p;

   initial begin
      // Reset, then a long idle stretch
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (50) tick();

      // Known payload, then a payload changed right after capture
      send(32'h12345678); nexp++; wait_done(nexp);
      send(32'h00000000); payload_in = 32'hFFFFFFFF; nexp++; wait_done(nexp);

      // Valid held high with alternating payloads: back-to-back frames
      payload_in = 32'h000000FF; payload_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = acc_cnt;
         wait_acc(a);
         if (i == 3) payload_valid = 1'b0;
         else payload_in = (payload_in == 32'h000000FF) ? 32'hAABBCCDD : 32'h000000FF;
         if (i >= 1) begin
            tick();
            chk("b2b_gap", 32'(last_start - last_done), 1);
         end
      end
      nexp += 4; wait_done(nexp);

      // Reset during the data bits of payload byte 1 (third byte on the line)
      send($urandom);
      t = 0;
      while (!(pos == 2 && mstate == 1 && bitn >= 1 && bitn <= 8) && t < 2000) begin tick(); t++; end
      chk("reach_byte2", 32'(pos), 2);
      rst = 1'b1; tick(); rst = 1'b0;
      d = n_done;
      repeat (300) tick();
      chk("no_done_after_abort", 32'(n_done), 32'(d));
      send(32'hC0FFEE11); nexp = n_done + 1; wait_done(nexp);

      // Random payloads, random gaps, payload_in disturbed while busy
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 5)) tick();
         p = $urandom;
         send(p);
         if ($urandom_range(0, 1) == 1) payload_in = $urandom;
         nexp++; wait_done(nexp);
      end

      repeat (5) tick();
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
